// File: rtl/mem2_load_unit_pkg.sv
// Shared CPU load definitions: load type descriptor and access size encodings.
package mem2_load_unit_pkg;

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   typedef struct packed {
      logic       ReadMem;
      logic       Sign;
      logic [1:0] Size;
   } load_type_t;

endpackage

// File: rtl/mem2_load_unit_align.sv
// Combinational load data alignment and sign/zero extension; shared with the uncached path.
module load_align
   import mem2_load_unit_pkg::*;
(
   input  logic [1:0]  addr_i,
   input  load_type_t  load_type_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr_i)
         2'b00:   byte_sel = data_i[7:0];
         2'b01:   byte_sel = data_i[15:8];
         2'b10:   byte_sel = data_i[23:16];
         default: byte_sel = data_i[31:24];
      endcase
      half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

      // Size 2'b11 falls through to the word case.
      case (load_type_i.Size)
         SizeByte: data_o = {{24{load_type_i.Sign & byte_sel[7]}}, byte_sel};
         SizeHalf: data_o = {{16{load_type_i.Sign & half_sel[15]}}, half_sel};
         default:  data_o = data_i;
      endcase
   end

endmodule

// File: rtl/mem2_load_unit.sv
// MEM2 load unit: waits for data cache read data, aligns it and stalls the pipe while missing.
module mem2_load_unit
   import mem2_load_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM2_Valid,
   input  load_type_t  MEM2_LoadType,
   input  logic [31:0] MEM2_ALUOut,
   input  logic        MEM2_Flush,
   input  logic        Pipe_Stall,
   input  logic        DCache_RdValid,
   input  logic [31:0] DCache_RdData,
   output logic [31:0] MEM2_LoadResult,
   output logic        MEM2_LoadValid,
   output logic        MEM2_LoadStall
);

   typedef enum logic [1:0] {StIdle, StWait, StHold, StDrain} state_e;

   state_e      state_q, state_d;
   logic [31:0] result_q, result_d;
   logic        valid_q, valid_d;
   logic [31:0] aligned;
   logic        pending;
   logic        unused_addr;

   assign unused_addr = ^MEM2_ALUOut[31:2];
   assign pending     = MEM2_Valid & MEM2_LoadType.ReadMem & ~MEM2_Flush;

   load_align u_load_align (
      .addr_i      (MEM2_ALUOut[1:0]),
      .load_type_i (MEM2_LoadType),
      .data_i      (DCache_RdData),
      .data_o      (aligned)
   );

   always_comb begin
      state_d        = state_q;
      result_d       = result_q;
      valid_d        = 1'b0;
      MEM2_LoadStall = 1'b0;
      case (state_q)
         StIdle, StWait: begin
            if (state_q == StWait && MEM2_Flush) begin
               // A beat arriving with the flush belongs to the killed load.
               state_d = DCache_RdValid ? StIdle : StDrain;
            end else if (pending && DCache_RdValid) begin
               result_d = aligned;
               valid_d  = 1'b1;
               state_d  = Pipe_Stall ? StHold : StIdle;
            end else if (pending) begin
               MEM2_LoadStall = 1'b1;
               state_d        = StWait;
            end else begin
               state_d = StIdle;
            end
         end
         StHold: begin
            valid_d = valid_q;
            if (MEM2_Flush) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end else if (!Pipe_Stall) begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            MEM2_LoadStall = pending;
            if (DCache_RdValid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         result_q <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign MEM2_LoadResult = result_q;
   assign MEM2_LoadValid  = valid_q;

endmodule

// File: tb/tb_mem2_load_unit.sv
// Directed and randomized bench for mem2_load_unit against a request-tracking reference model.
module tb_mem2_load_unit;
   import mem2_load_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM2_Valid;
   load_type_t  MEM2_LoadType;
   logic [31:0] MEM2_ALUOut;
   logic        MEM2_Flush;
   logic        Pipe_Stall;
   logic        DCache_RdValid;
   logic [31:0] DCache_RdData;
   logic [31:0] MEM2_LoadResult;
   logic        MEM2_LoadValid;
   logic        MEM2_LoadStall;

   int checks   = 0;
   int failures = 0;

   // Reference model: what the unit owes the pipeline, tracked as flags.
   logic [31:0] m_res;
   bit          m_vld, m_waiting, m_owe_beat, m_holding;

   always #5 clk = ~clk;

   mem2_load_unit dut (
      .clk             (clk),
      .rst             (rst),
      .MEM2_Valid      (MEM2_Valid),
      .MEM2_LoadType   (MEM2_LoadType),
      .MEM2_ALUOut     (MEM2_ALUOut),
      .MEM2_Flush      (MEM2_Flush),
      .Pipe_Stall      (Pipe_Stall),
      .DCache_RdValid  (DCache_RdValid),
      .DCache_RdData   (DCache_RdData),
      .MEM2_LoadResult (MEM2_LoadResult),
      .MEM2_LoadValid  (MEM2_LoadValid),
      .MEM2_LoadStall  (MEM2_LoadStall)
   );

   function automatic logic [31:0] ref_align(logic [1:0] a, logic s, logic [1:0] sz,
                                             logic [31:0] d);
      int          bits;
      int          sh;
      logic [63:0] v;
      logic [63:0] mask;
      bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
      sh   = (sz == 2'b00) ? 8 * int'(a) : (sz == 2'b01) ? 16 * int'(a[1]) : 0;
      mask = (64'd1 << bits) - 64'd1;
      v    = ({32'h0, d} >> sh) & mask;
      if (s && bits < 32 && v[bits-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_res      = 32'h0;
      m_vld      = 1'b0;
      m_waiting  = 1'b0;
      m_owe_beat = 1'b0;
      m_holding  = 1'b0;
   endtask

   // One pipeline cycle: drive, check stall before the edge, then check registered outputs.
   task automatic cyc(input logic v, input logic rm, input logic sg, input logic [1:0] sz,
                      input logic [31:0] addr, input logic fl, input logic ps,
                      input logic rdv, input logic [31:0] d, output logic stall_seen);
      bit pend;
      bit exp_stall;
      MEM2_Valid     = v;
      MEM2_LoadType  = '{ReadMem: rm, Sign: sg, Size: sz};
      MEM2_ALUOut    = addr;
      MEM2_Flush     = fl;
      Pipe_Stall     = ps;
      DCache_RdValid = rdv;
      DCache_RdData  = d;
      pend      = v && rm && !fl;
      exp_stall = m_holding ? 1'b0 : m_owe_beat ? pend : (pend && !rdv);
      #2;
      stall_seen = MEM2_LoadStall;
      chk("stall", {31'h0, MEM2_LoadStall}, {31'h0, exp_stall});
      @(posedge clk);
      #1;
      if (m_holding) begin
         if (fl) begin
            m_vld     = 1'b0;
            m_holding = 1'b0;
         end else if (!ps) begin
            m_holding = 1'b0;
         end
      end else if (m_owe_beat) begin
         m_vld = 1'b0;
         if (rdv) m_owe_beat = 1'b0;
      end else begin
         m_vld = 1'b0;
         if (m_waiting && fl) begin
            m_waiting  = 1'b0;
            m_owe_beat = !rdv;
         end else if (pend && rdv) begin
            m_res     = ref_align(addr[1:0], sg, sz, d);
            m_vld     = 1'b1;
            m_waiting = 1'b0;
            m_holding = ps;
         end else begin
            m_waiting = pend;
         end
      end
      chk("result", MEM2_LoadResult, m_res);
      chk("valid", {31'h0, MEM2_LoadValid}, {31'h0, m_vld});
   endtask

   task automatic idle_cyc();
      logic s;
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, s);
   endtask

   initial begin
      logic st;
      int   nstall;
      rst            = 1'b0;
      MEM2_Valid     = 1'b0;
      MEM2_LoadType  = '0;
      MEM2_ALUOut    = 32'h0;
      MEM2_Flush     = 1'b0;
      Pipe_Stall     = 1'b0;
      DCache_RdValid = 1'b0;
      DCache_RdData  = 32'h0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_result", MEM2_LoadResult, 32'h0);
      chk("rst_valid", {31'h0, MEM2_LoadValid}, 32'h0);
      chk("rst_stall", {31'h0, MEM2_LoadStall}, 32'h0);
      rst = 1'b1;

      // Signed byte, top lane, same-cycle hit.
      cyc(1'b1, 1'b1, 1'b1, SizeByte, 32'h0000_1003, 1'b0, 1'b0, 1'b1, 32'h80AB_CD12, st);
      chk("lb_stall", {31'h0, st}, 32'h0);
      chk("lb_result", MEM2_LoadResult, 32'hFFFF_FF80);
      chk("lb_valid", {31'h0, MEM2_LoadValid}, 32'h1);
      idle_cyc();
      chk("lb_valid_clr", {31'h0, MEM2_LoadValid}, 32'h0);

      // Unsigned half, upper lane, data three cycles late.
      nstall = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, SizeHalf, 32'h2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, st);
         nstall += int'(st);
      end
      cyc(1'b1, 1'b1, 1'b0, SizeHalf, 32'h2, 1'b0, 1'b0, 1'b1, 32'hBEEF_0001, st);
      nstall += int'(st);
      chk("lhu_stall_cycles", nstall, 32'd3);
      chk("lhu_result", MEM2_LoadResult, 32'h0000_BEEF);

      // Word hit under a two-cycle downstream stall; second beat must be ignored.
      cyc(1'b1, 1'b1, 1'b0, SizeWord, 32'h0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, st);
      cyc(1'b1, 1'b1, 1'b0, SizeWord, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0000, st);
      chk("hold_result", MEM2_LoadResult, 32'hCAFE_F00D);
      chk("hold_valid", {31'h0, MEM2_LoadValid}, 32'h1);
      chk("hold_stall", {31'h0, st}, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, SizeWord, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, st);
      chk("hold_exit_result", MEM2_LoadResult, 32'hCAFE_F00D);
      idle_cyc();
      chk("hold_valid_clr", {31'h0, MEM2_LoadValid}, 32'h0);

      // Flush while waiting; the late beat is drained, the next load gets its own data.
      cyc(1'b1, 1'b1, 1'b0, SizeWord, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, st);
      cyc(1'b1, 1'b1, 1'b0, SizeWord, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, st);
      cyc(1'b0, 1'b0, 1'b0, SizeWord, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, st);
      chk("drain_valid", {31'h0, MEM2_LoadValid}, 32'h0);
      chk("drain_result", MEM2_LoadResult, 32'hCAFE_F00D);
      cyc(1'b1, 1'b1, 1'b0, SizeWord, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0A0B_0C0D, st);
      chk("after_drain_result", MEM2_LoadResult, 32'h0A0B_0C0D);

      // Reset pulse in the middle of a wait.
      cyc(1'b1, 1'b1, 1'b0, SizeByte, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, st);
      MEM2_Valid     = 1'b0;
      MEM2_LoadType  = '0;
      DCache_RdValid = 1'b0;
      rst            = 1'b0;
      model_reset();
      #2;
      chk("mid_rst_result", MEM2_LoadResult, 32'h0);
      chk("mid_rst_valid", {31'h0, MEM2_LoadValid}, 32'h0);
      chk("mid_rst_stall", {31'h0, MEM2_LoadStall}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, SizeByte, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_007F, st);
      chk("post_rst_result", MEM2_LoadResult, 32'h0000_007F);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(9) < 7), ($urandom_range(9) < 7), 1'($urandom),
             2'($urandom), $urandom, ($urandom_range(9) == 0), ($urandom_range(3) == 0),
             1'($urandom), $urandom, st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem2_load_unit.md
MEM2_LOAD_UNIT -- requirements
Module: mem2_load_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk is the clock, rst is the reset, active-low asynchronous.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- MEM2_Valid  in  1  the MEM2 register holds a live instruction.
- MEM2_LoadType  in  LoadType  ReadMem, Sign, Size[1:0] (00 byte, 01 half, 10 word).
- MEM2_ALUOut  in  32  load address; only bits [1:0] are used.
- MEM2_Flush  in  1  kills the MEM2 instruction this cycle.
- Pipe_Stall  in  1  global stall from downstream; the MEM2 register is held.
- DCache_RdValid  in  1  read data is valid this cycle.
- DCache_RdData  in  32  raw word from the data cache.
- MEM2_LoadResult  out  32  aligned, extended load data, registered.
- MEM2_LoadValid  out  1  MEM2_LoadResult belongs to the current MEM2 instruction.
- MEM2_LoadStall  out  1  holds IF..MEM2 until load data arrives.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, WAIT, HOLD, DRAIN.
REQ-004 SHALL define Pending = MEM2_Valid & ReadMem & !MEM2_Flush.
REQ-005 IDLE or WAIT, Pending, DCache_RdValid=1: SHALL register the aligned data into MEM2_LoadResult, set MEM2_LoadValid, and keep MEM2_LoadStall=0 that cycle. The next state is HOLD if Pipe_Stall=1, else IDLE.
REQ-006 IDLE or WAIT, Pending, DCache_RdValid=0: SHALL assert MEM2_LoadStall combinationally and go to or stay in WAIT.
REQ-007 HOLD: SHALL keep MEM2_LoadResult and MEM2_LoadValid constant, assert no stall, and ignore DCache_RdValid. It SHALL return to IDLE on the first cycle Pipe_Stall=0.
REQ-008 WAIT with MEM2_Flush=1 and DCache_RdValid=0: SHALL go to DRAIN. With DCache_RdValid=1 the data SHALL be discarded and the FSM go to IDLE.
REQ-009 DRAIN: SHALL discard exactly one DCache_RdValid beat, then go to IDLE. It SHALL assert MEM2_LoadStall while Pending.
REQ-010 Flush in HOLD: SHALL clear MEM2_LoadValid next cycle and go to IDLE.
REQ-011 SHALL clear MEM2_LoadValid on the cycle after the FSM leaves HOLD, or after a capture with Pipe_Stall=0.
REQ-012 Alignment:
- Byte lane = addr[1:0]; halfword lane = addr[1].
- Word uses the full data.
- Sign=1 sign-extends to 32; Sign=0 zero-extends.
- Size=11 is treated as word.
REQ-013 Load latency SHALL be 0 stall cycles for a same-cycle hit and N stall cycles for N cycles of DCache_RdValid=0.
REQ-014 Non-load instructions SHALL never assert MEM2_LoadStall or change MEM2_LoadResult.

Reset
REQ-015 While rst=0: state=IDLE, MEM2_LoadResult=32'h0, MEM2_LoadValid=0, MEM2_LoadStall=0. Reset mid-WAIT SHALL drop the outstanding beat with no DRAIN.

Structure
REQ-016 LoadType and the size encodings SHALL live in the shared CPU defines package; the FSM state enum SHALL be local.
REQ-017 Alignment/extension SHALL be a combinational sub-module, load_align, that is reusable by the uncached path.

Verification
REQ-018 LB, Sign=1, addr=2'b11, data=32'h80AB_CD12 with same-cycle valid -> result 32'hFFFF_FF80, valid=1 next cycle, no stall.
REQ-019 LHU, addr=2'b10, valid delayed 3 cycles, data=32'hBEEF_0001 -> stall high exactly 3 cycles, result 32'h0000_BEEF.
REQ-020 LW hit while Pipe_Stall=1 for 2 cycles, then a second DCache_RdValid beat of 32'hDEAD_0000 -> state HOLD, result remains the first word until Pipe_Stall=0.
REQ-021 Flush in WAIT, then a beat of 32'h1234_5678 -> beat discarded in DRAIN, valid stays 0; the next LW captures its own data.
REQ-022 rst pulse low during WAIT -> state IDLE, all outputs 0; a subsequent LB at addr 0 of 32'h0000_007F -> 32'h0000_007F.
